// File: rtl/rs_pkg.sv
// rs_pkg: shared FSM state type, counter width and parameter defaults for rs_drive_ctrl
package rs_pkg;
  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;
  localparam int CNT_W = 8;
  localparam int DEB_DEF = 4;
  localparam int PULSE_DEF = 3;
  localparam int GAP_DEF = 2;
endpackage

// File: rtl/rs_drive_ctrl_if.sv
// rs_drive_ctrl_if: request inputs and latch drive outputs of rs_drive_ctrl
// RS_FEEDBACK_CHECK_EN adds latch feedback inputs Q_FB/QB_FB and the sticky FB_ERR flag
interface rs_drive_ctrl_if;
  logic SET_IN, CLR_IN, S, R, Q_EXP, BUSY, DROP, CONFLICT;
`ifdef RS_FEEDBACK_CHECK_EN
  logic Q_FB, QB_FB, FB_ERR;
  modport master (output SET_IN, CLR_IN, Q_FB, QB_FB, input S, R, Q_EXP, BUSY, DROP, CONFLICT, FB_ERR);
  modport slave (input SET_IN, CLR_IN, Q_FB, QB_FB, output S, R, Q_EXP, BUSY, DROP, CONFLICT, FB_ERR);
`else
  modport master (output SET_IN, CLR_IN, input S, R, Q_EXP, BUSY, DROP, CONFLICT);
  modport slave (input SET_IN, CLR_IN, output S, R, Q_EXP, BUSY, DROP, CONFLICT);
`endif
endinterface

// File: rtl/rs_debounce.sv
// rs_debounce: two-flop synchroniser, counting debouncer and rising-edge request for one raw input
module rs_debounce import rs_pkg::*; #(
  parameter int DEB_CYCLES = DEB_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_raw,
  output logic o_rise
);
  localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEB_CYCLES - 1);
  logic [1:0] r_sync;
  logic r_deb, r_deb_d;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
      r_deb <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_deb_d <= r_deb;
      if (r_sync[1] == r_deb) r_cnt <= '0;
      else if (r_cnt == DEB_M1) begin
        r_deb <= r_sync[1];
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_rise = r_deb & ~r_deb_d;
endmodule

// File: rtl/rs_drive_ctrl.sv
// rs_drive_ctrl: debounced set/clear requests to fixed-width, never-overlapping S/R latch pulses
// RS_FEEDBACK_CHECK_EN enables the sticky latch feedback comparison (FB_ERR)
module rs_drive_ctrl import rs_pkg::*; #(
  parameter int DEB_CYCLES = DEB_DEF,
  parameter int PULSE_CYCLES = PULSE_DEF,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input logic CLK,
  input logic RST,
  rs_drive_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_CYCLES - 1);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_q, r_drop, r_conf;
  logic w_req_s, w_req_c, w_last, w_exit, w_after;
  rs_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s (.CLK(CLK), .RST(RST), .i_raw(bus.SET_IN), .o_rise(w_req_s));
  rs_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_c (.CLK(CLK), .RST(RST), .i_raw(bus.CLR_IN), .o_rise(w_req_c));
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_q <= 1'b0;
      r_drop <= 1'b0;
      r_conf <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
      r_q <= w_exit ? (r_state == SET_P) : r_q;
      r_drop <= (w_req_s | w_req_c) && r_state != IDLE;
      r_conf <= w_req_s && w_req_c && r_state == IDLE;
    end
  end
  always_comb begin
    w_last = (r_state == GAP) ? (r_cnt == GAP_M1) : (r_cnt == PULSE_M1);
    w_exit = (r_state == SET_P || r_state == CLR_P) && w_last;
    w_after = (GAP_CYCLES == 0) ? IDLE : GAP;
    w_next = r_state;
    if (r_state == IDLE) w_next = (w_req_s && !w_req_c) ? SET_P : (w_req_c && !w_req_s) ? CLR_P : IDLE;
    else if (r_state == GAP) w_next = w_last ? IDLE : GAP;
    else if (w_exit) w_next = w_after ? GAP : IDLE;
  end
  always_comb begin
    bus.S = r_state == SET_P;
    bus.R = r_state == CLR_P;
    bus.BUSY = r_state != IDLE;
    bus.Q_EXP = r_q;
    bus.DROP = r_drop;
    bus.CONFLICT = r_conf;
  end
`ifdef RS_FEEDBACK_CHECK_EN
  // compare the latch one cycle after a pulse ends, once Q_EXP has updated
  logic r_chk, r_fb_err;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chk <= 1'b0;
      r_fb_err <= 1'b0;
    end else begin
      r_chk <= w_exit;
      if (r_chk && (bus.Q_FB != r_q || bus.QB_FB == bus.Q_FB)) r_fb_err <= 1'b1;
    end
  end
  assign bus.FB_ERR = r_fb_err;
`endif
endmodule

// File: tb/tb_rs_drive_ctrl.sv
// tb_rs_drive_ctrl: directed self-checking bench for rs_drive_ctrl with default parameters
module tb_rs_drive_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int failures = 0;
  rs_drive_ctrl_if bus();
  rs_drive_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    checks++;
    if ((bus.S & bus.R) !== 1'b0) begin
      failures++;
      $display("FAIL s_r_exclusive t=%0t got S=%b R=%b required not both 1", $time, bus.S, bus.R);
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic test_reset();
    RST = 1'b1;
    bus.SET_IN = 1'b0;
    bus.CLR_IN = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.S, bus.R, bus.Q_EXP, bus.BUSY, bus.DROP, bus.CONFLICT} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=000000", {bus.S, bus.R, bus.Q_EXP, bus.BUSY, bus.DROP, bus.CONFLICT});
    end
    RST = 1'b0;
  endtask
  task automatic test_set();
    bus.SET_IN = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (bus.S !== (n >= 7 && n <= 9)) begin
        failures++;
        $display("FAIL set_s n=%0d got=%b required=%b", n, bus.S, n >= 7 && n <= 9);
      end
      checks++;
      if (bus.R !== 1'b0) begin
        failures++;
        $display("FAIL set_r n=%0d got=%b required=0", n, bus.R);
      end
      checks++;
      if (bus.BUSY !== (n >= 7 && n <= 11)) begin
        failures++;
        $display("FAIL set_busy n=%0d got=%b required=%b", n, bus.BUSY, n >= 7 && n <= 11);
      end
      checks++;
      if (bus.Q_EXP !== (n >= 10)) begin
        failures++;
        $display("FAIL set_qexp n=%0d got=%b required=%b", n, bus.Q_EXP, n >= 10);
      end
    end
    bus.SET_IN = 1'b0;
    idle_wait(10);
  endtask
  task automatic test_conflict();
    bus.SET_IN = 1'b1;
    bus.CLR_IN = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (bus.CONFLICT !== (n == 7)) begin
        failures++;
        $display("FAIL conflict_pulse n=%0d got=%b required=%b", n, bus.CONFLICT, n == 7);
      end
      checks++;
      if ({bus.S, bus.R, bus.BUSY, bus.Q_EXP} !== 4'b0001) begin
        failures++;
        $display("FAIL conflict_srbq n=%0d got=%b required=0001", n, {bus.S, bus.R, bus.BUSY, bus.Q_EXP});
      end
    end
    bus.SET_IN = 1'b0;
    bus.CLR_IN = 1'b0;
    idle_wait(10);
  endtask
  task automatic test_glitch_clear();
    bus.CLR_IN = 1'b1;
    tick();
    tick();
    bus.CLR_IN = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if ({bus.S, bus.R, bus.BUSY} !== 3'b000) begin
        failures++;
        $display("FAIL glitch_quiet n=%0d got=%b required=000", n, {bus.S, bus.R, bus.BUSY});
      end
    end
    bus.CLR_IN = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (bus.R !== (n >= 7 && n <= 9)) begin
        failures++;
        $display("FAIL clear_r n=%0d got=%b required=%b", n, bus.R, n >= 7 && n <= 9);
      end
      checks++;
      if (bus.Q_EXP !== (n < 10)) begin
        failures++;
        $display("FAIL clear_qexp n=%0d got=%b required=%b", n, bus.Q_EXP, n < 10);
      end
    end
    bus.CLR_IN = 1'b0;
    idle_wait(10);
  endtask
  task automatic test_drop();
    bus.SET_IN = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      if (n == 3) bus.CLR_IN = 1'b1;
      tick();
      checks++;
      if (bus.S !== (n >= 7 && n <= 9)) begin
        failures++;
        $display("FAIL drop_s n=%0d got=%b required=%b", n, bus.S, n >= 7 && n <= 9);
      end
      checks++;
      if (bus.R !== 1'b0) begin
        failures++;
        $display("FAIL drop_r n=%0d got=%b required=0", n, bus.R);
      end
      checks++;
      if (bus.DROP !== (n == 9)) begin
        failures++;
        $display("FAIL drop_pulse n=%0d got=%b required=%b", n, bus.DROP, n == 9);
      end
    end
    bus.SET_IN = 1'b0;
    bus.CLR_IN = 1'b0;
    idle_wait(10);
  endtask
  task automatic test_reset_mid();
    bus.SET_IN = 1'b1;
    for (int n = 1; n <= 8; n++) tick();
    checks++;
    if (bus.S !== 1'b1) begin
      failures++;
      $display("FAIL mid_s_before got=%b required=1", bus.S);
    end
    RST = 1'b1;
    bus.SET_IN = 1'b0;
    tick();
    checks++;
    if ({bus.S, bus.Q_EXP, bus.BUSY} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset got=%b required=000", {bus.S, bus.Q_EXP, bus.BUSY});
    end
    RST = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if ({bus.S, bus.R, bus.BUSY} !== 3'b000) begin
        failures++;
        $display("FAIL mid_after n=%0d got=%b required=000", n, {bus.S, bus.R, bus.BUSY});
      end
    end
  endtask
`ifdef RS_FEEDBACK_CHECK_EN
  task automatic test_feedback();
    bus.Q_FB = 1'b0;
    bus.QB_FB = 1'b1;
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.FB_ERR !== 1'b0) begin
      failures++;
      $display("FAIL fb_reset got=%b required=0", bus.FB_ERR);
    end
    RST = 1'b0;
    bus.SET_IN = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (bus.FB_ERR !== (n >= 11)) begin
        failures++;
        $display("FAIL fb_err n=%0d got=%b required=%b", n, bus.FB_ERR, n >= 11);
      end
    end
    bus.SET_IN = 1'b0;
    idle_wait(10);
    checks++;
    if (bus.FB_ERR !== 1'b1) begin
      failures++;
      $display("FAIL fb_sticky got=%b required=1", bus.FB_ERR);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (bus.FB_ERR !== 1'b0) begin
      failures++;
      $display("FAIL fb_clear got=%b required=0", bus.FB_ERR);
    end
    RST = 1'b0;
  endtask
`endif
  initial begin
`ifdef RS_FEEDBACK_CHECK_EN
    bus.Q_FB = 1'b0;
    bus.QB_FB = 1'b1;
`endif
    test_reset();
    test_set();
    test_conflict();
    test_glitch_clear();
    test_drop();
    test_reset_mid();
`ifdef RS_FEEDBACK_CHECK_EN
    test_feedback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_drive_ctrl.md
Name: rs_drive_ctrl

Overview:
Clocked command front-end that sits directly upstream of the RS latch and drives its S and R inputs. It synchronises and debounces two raw request inputs (set, clear) and converts each accepted request into a fixed-width S or R pulse. It guarantees the latch never sees the forbidden S=R=1 combination and keeps a registered copy of the expected latch state.

Parameters:
DEB_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates (1..255)
PULSE_CYCLES, 3, width in cycles of each S or R pulse (1..255)
GAP_CYCLES, 2, minimum cycles with S=R=0 after a pulse before the next pulse may start (0..255)

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  reset, synchronous, active-high
SET_IN  in  1  raw asynchronous set request (button level)
CLR_IN  in  1  raw asynchronous clear request (button level)
S  out  1  set drive to the latch
R  out  1  reset drive to the latch
Q_EXP  out  1  expected latch Q after the last completed pulse
BUSY  out  1  high in any state other than IDLE
DROP  out  1  one-cycle pulse: request edge rejected because the block was busy
CONFLICT  out  1  one-cycle pulse: set and clear edges in the same cycle; neither is served

Behaviour:
- Reset: one clock, synchronous, active-high. While RST=1 at a rising edge: S=0, R=0, Q_EXP=0, BUSY=0, DROP=0, CONFLICT=0; synchroniser flops, debounced values, counters cleared; state=IDLE. Reset mid-pulse drops S/R on the same edge.
- Synchroniser: two flops per input.
- Debounce per input: the counter increments while the synchronised value differs from the debounced value and clears when they match. When the count reaches DEB_CYCLES, the debounced value takes the synchronised value and the counter clears. A glitch shorter than DEB_CYCLES cycles has no effect.
- Edge detect: a rising edge of a debounced value produces a one-cycle request. Falling edges are ignored.
- FSM states IDLE, SET_P, CLR_P, GAP:
  IDLE: set request only -> SET_P. Clear request only -> CLR_P. Both in the same cycle -> CONFLICT=1 for one cycle, stay in IDLE.
  SET_P: S=1 for exactly PULSE_CYCLES cycles. On the last cycle Q_EXP<=1 and the state moves to GAP, or to IDLE if GAP_CYCLES=0.
  CLR_P: R=1 for exactly PULSE_CYCLES cycles. On exit Q_EXP<=0, then to GAP or IDLE as for SET_P.
  GAP: S=R=0 for GAP_CYCLES cycles, then IDLE.
- S and R are registered outputs and are never both 1. The bench asserts this invariant every cycle.
- Requests arriving in any state other than IDLE are discarded. DROP=1 for the cycle after the rejected edge.
- Latency: raw input high and stable -> S or R high after 2 (sync) + DEB_CYCLES + 1 cycles (7 with defaults).
- Counters are sized to 8 bits. No wrap is possible within the legal parameter ranges.

Optional Feature:
RS_FEEDBACK_CHECK_EN.
- Defined: adds inputs Q_FB and QB_FB (1 bit each) from the latch outputs, plus output FB_ERR (1 bit). FB_ERR is sticky.
  On the first GAP/IDLE cycle after a pulse, FB_ERR sets if Q_FB != Q_EXP or QB_FB == Q_FB.
  FB_ERR clears only on RST.
- Undefined: none of these ports exist and no comparison logic is built.

Decomposition:
- Shared package rs_pkg: FSM state enum (IDLE, SET_P, CLR_P, GAP), counter width constant CNT_W=8, and default values for DEB_CYCLES, PULSE_CYCLES and GAP_CYCLES.
- One sub-module, rs_debounce (synchroniser + debounce + rising-edge detect), instantiated twice, once per input.
- The FSM and output registers live in the top module.

Test Plan:
- Defaults. RST high 2 cycles, then SET_IN=1 held -> S=1 from cycle 7 for exactly 3 cycles, R=0 throughout, Q_EXP=1 after the pulse, BUSY low 2 cycles after S falls.
- CLR_IN 2-cycle glitch (shorter than DEB_CYCLES=4) -> S=R=0, BUSY=0 throughout. Then CLR_IN held -> R pulse of 3 cycles, Q_EXP=0.
- SET_IN and CLR_IN rise in the same cycle -> CONFLICT pulses once, S=R=0, Q_EXP unchanged.
- SET_IN pulse accepted; CLR_IN rises so its debounced edge lands during SET_P -> DROP pulses once, no R pulse follows.
- RST asserted during the second cycle of an S pulse -> next edge S=0, Q_EXP=0, BUSY=0. After RST deasserts, no pulse occurs without a new input edge.
- With RS_FEEDBACK_CHECK_EN: Q_FB tied to 0, set request served -> FB_ERR=1 after the pulse and stays 1 until RST.
